// File: rtl/sopc_run_monitor.sv
// Run controller and writeback tracer for the minimum SOPC.
// Holds the CPU in reset for a fixed number of cycles, lets it run for a
// bounded window, then halts it. While the CPU runs, every non-$0 register
// file write is stamped with the run cycle and queued in a FWFT trace FIFO.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start, CPU held in reset
// RESET  | CPU held in reset for RESET_CYCLES cycles
// RUN    | CPU released for RUN_CYCLES cycles, writebacks are traced
// HALT   | CPU held in reset again, trace still readable, start restarts
module sopc_run_monitor #(
    parameter int RESET_CYCLES = 10,
    parameter int RUN_CYCLES   = 150,
    parameter int TRACE_DEPTH  = 16,
    parameter int REG_ADDR_W   = 5,
    parameter int DATA_W       = 32,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  cpu_rst,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0]     wb_wdata,
    output logic                  trace_valid,
    input  logic                  trace_ready,
    output logic [REG_ADDR_W-1:0] trace_addr,
    output logic [DATA_W-1:0]     trace_data,
    output logic [CNT_W-1:0]      trace_cycle,
    output logic                  trace_overflow,
    output logic [1:0]            state,
    output logic [CNT_W-1:0]      cycle_cnt,
    output logic                  done
);

    localparam int PTR_W   = $clog2(TRACE_DEPTH);
    localparam int ENTRY_W = CNT_W + REG_ADDR_W + DATA_W;

    localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_CYCLES - 1);
    localparam logic [PTR_W:0]   DEPTH_CNT  = (PTR_W + 1)'(TRACE_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RESET = 2'b01,
        ST_RUN   = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    state_t st;

    logic [ENTRY_W-1:0] mem [TRACE_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;

    logic flush;
    logic push_req;
    logic full;
    logic pop;
    logic push;

    assign state = st;

    // Restarting from HALT discards the previous run's trace and overflow flag.
    assign flush    = (st == ST_HALT) && start;
    assign push_req = (st == ST_RUN) && wb_we && (wb_waddr != '0);
    assign full     = (count == DEPTH_CNT);
    assign trace_valid = (count != '0);
    assign pop      = trace_valid && trace_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push     = push_req && (!full || pop);

    assign {trace_cycle, trace_addr, trace_data} = mem[rd_ptr];

    // Sequencer: phase transitions, phase cycle counter, registered cpu_rst/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= ST_IDLE;
            cpu_rst   <= 1'b1;
            done      <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (start) begin
                        st        <= ST_RESET;
                        cycle_cnt <= '0;
                    end
                end
                ST_RESET: begin
                    if (cycle_cnt == RESET_LAST) begin
                        st        <= ST_RUN;
                        cycle_cnt <= '0;
                        cpu_rst   <= 1'b0;
                    end else begin
                        cycle_cnt <= cycle_cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (cycle_cnt == RUN_LAST) begin
                        st      <= ST_HALT;
                        cpu_rst <= 1'b1;
                        done    <= 1'b1;
                    end else begin
                        cycle_cnt <= cycle_cnt + CNT_W'(1);
                    end
                end
                ST_HALT: begin
                    if (start) begin
                        st        <= ST_RESET;
                        cycle_cnt <= '0;
                        done      <= 1'b0;
                    end
                end
                default: begin
                    st      <= ST_IDLE;
                    cpu_rst <= 1'b1;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    // Trace storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cycle_cnt, wb_waddr, wb_wdata};
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            trace_overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
            if (push_req && full && !pop) begin
                trace_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sopc_run_monitor.sv
// Directed bench for sopc_run_monitor with default parameters.
module tb_sopc_run_monitor;

    logic        clk;
    logic        rst;
    logic        start;
    logic        cpu_rst;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        trace_valid;
    logic        trace_ready;
    logic [4:0]  trace_addr;
    logic [31:0] trace_data;
    logic [15:0] trace_cycle;
    logic        trace_overflow;
    logic [1:0]  state;
    logic [15:0] cycle_cnt;
    logic        done;

    int checks;
    int failures;
    int low_cycles;
    int n;

    sopc_run_monitor #(
        .RESET_CYCLES(10),
        .RUN_CYCLES  (150),
        .TRACE_DEPTH (16),
        .REG_ADDR_W  (5),
        .DATA_W      (32),
        .CNT_W       (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cpu_rst       (cpu_rst),
        .wb_we         (wb_we),
        .wb_waddr      (wb_waddr),
        .wb_wdata      (wb_wdata),
        .trace_valid   (trace_valid),
        .trace_ready   (trace_ready),
        .trace_addr    (trace_addr),
        .trace_data    (trace_data),
        .trace_cycle   (trace_cycle),
        .trace_overflow(trace_overflow),
        .state         (state),
        .cycle_cnt     (cycle_cnt),
        .done          (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts clock edges at which the CPU is out of reset.
    always @(posedge clk) begin
        if (cpu_rst === 1'b0) low_cycles++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [4:0] a, input logic [31:0] d,
                              input logic [15:0] c);
        check({tag, "_valid"}, {63'd0, trace_valid}, 64'd1);
        check({tag, "_addr"},  {59'd0, trace_addr},  {59'd0, a});
        check({tag, "_data"},  {32'd0, trace_data},  {32'd0, d});
        check({tag, "_cycle"}, {48'd0, trace_cycle}, {48'd0, c});
    endtask

    task automatic wait_cnt(input string tag, input logic [15:0] v);
        int k;
        k = 0;
        while (cycle_cnt !== v && k < 300) begin
            step();
            k++;
        end
        check(tag, {48'd0, cycle_cnt}, {48'd0, v});
    endtask

    task automatic wait_run(input string tag);
        int k;
        k = 0;
        while (cpu_rst !== 1'b0 && k < 50) begin
            step();
            k++;
        end
        check(tag, 64'(k), 64'd10);
    endtask

    task automatic wait_halt(input string tag);
        int k;
        k = 0;
        while (state !== 2'b11 && k < 300) begin
            step();
            k++;
        end
        check(tag, {62'd0, state}, 64'd3);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wb_we    = 1'b1;
        wb_waddr = a;
        wb_wdata = d;
        step();
        wb_we    = 1'b0;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        low_cycles  = 0;
        rst         = 1'b1;
        start       = 1'b0;
        wb_we       = 1'b0;
        wb_waddr    = '0;
        wb_wdata    = '0;
        trace_ready = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_state",    {62'd0, state},          64'd0);
        check("rst_cpu_rst",  {63'd0, cpu_rst},        64'd1);
        check("rst_cnt",      {48'd0, cycle_cnt},      64'd0);
        check("rst_valid",    {63'd0, trace_valid},    64'd0);
        check("rst_overflow", {63'd0, trace_overflow}, 64'd0);
        check("rst_done",     {63'd0, done},           64'd0);
        rst = 1'b0;
        step();
        check("idle_state", {62'd0, state}, 64'd0);

        // Run 1: sequencing, basic capture, $0 filter, ignored start, last-cycle capture
        start = 1'b1;
        step();
        start = 1'b0;
        check("reset_state",   {62'd0, state},   64'd1);
        check("reset_cpu_rst", {63'd0, cpu_rst}, 64'd1);
        low_cycles = 0;
        wait_run("reset_len");
        check("run_state", {62'd0, state},     64'd2);
        check("run_cnt0",  {48'd0, cycle_cnt}, 64'd0);

        repeat (5) step();
        wr(5'd1, 32'h1100);
        check_head("cap1", 5'd1, 32'h1100, 16'd5);
        wr(5'd0, 32'hDEAD);
        check_head("cap1_after_r0", 5'd1, 32'h1100, 16'd5);
        wr(5'd2, 32'hBEEF);
        trace_ready = 1'b1;
        check_head("drain1", 5'd1, 32'h1100, 16'd5);
        step();
        check_head("drain2", 5'd2, 32'hBEEF, 16'd7);
        step();
        check("drain_empty", {63'd0, trace_valid}, 64'd0);
        trace_ready = 1'b0;
        check("cnt_before_start", {48'd0, cycle_cnt}, 64'd10);
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_in_run_state", {62'd0, state},     64'd2);
        check("start_in_run_cnt",   {48'd0, cycle_cnt}, 64'd11);

        wait_cnt("reach_149", 16'd149);
        check("last_run_cpu_rst", {63'd0, cpu_rst}, 64'd0);
        wr(5'd3, 32'h149);
        check("halt_state", {62'd0, state},     64'd3);
        check("halt_done",  {63'd0, done},      64'd1);
        check("halt_cnt",   {48'd0, cycle_cnt}, 64'd149);
        wr(5'd4, 32'h150);
        check("run_len",    64'(low_cycles),     64'd150);
        check("halt_cpu_rst", {63'd0, cpu_rst}, 64'd1);
        check("halt_cnt_hold", {48'd0, cycle_cnt}, 64'd149);
        check_head("last_cap", 5'd3, 32'h149, 16'd149);
        trace_ready = 1'b1;
        step();
        check("halt_write_dropped", {63'd0, trace_valid}, 64'd0);
        trace_ready = 1'b0;

        // Run 2: overflow
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_state", {62'd0, state}, 64'd1);
        check("restart_done",  {63'd0, done},  64'd0);
        wait_run("reset_len2");
        for (int i = 0; i < 17; i++) begin
            wr(5'(i + 1), 32'hA000 + 32'(i));
        end
        check("ovf_set", {63'd0, trace_overflow}, 64'd1);
        trace_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_head($sformatf("ovf_drain%0d", i), 5'(i + 1), 32'hA000 + 32'(i), 16'(i));
            step();
        end
        check("ovf_drained", {63'd0, trace_valid}, 64'd0);
        trace_ready = 1'b0;
        wait_halt("halt2");
        check("ovf_sticky", {63'd0, trace_overflow}, 64'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("ovf_cleared", {63'd0, trace_overflow}, 64'd0);

        // Run 3: full FIFO push+pop, then rst mid-run with entries queued
        wait_run("reset_len3");
        for (int i = 0; i < 16; i++) begin
            wr(5'(i + 1), 32'hB000 + 32'(i));
        end
        check("full_no_ovf", {63'd0, trace_overflow}, 64'd0);
        trace_ready = 1'b1;
        wr(5'd20, 32'hC0DE);
        check("pushpop_no_ovf", {63'd0, trace_overflow}, 64'd0);
        for (int i = 1; i < 16; i++) begin
            check_head($sformatf("pp_drain%0d", i), 5'(i + 1), 32'hB000 + 32'(i), 16'(i));
            step();
        end
        check_head("pp_last", 5'd20, 32'hC0DE, 16'd16);
        step();
        check("pp_empty", {63'd0, trace_valid}, 64'd0);
        trace_ready = 1'b0;

        wait_cnt("reach_34", 16'd34);
        wr(5'd7, 32'h7);
        wr(5'd8, 32'h8);
        wr(5'd9, 32'h9);
        wait_cnt("reach_40", 16'd40);
        check_head("queued", 5'd7, 32'h7, 16'd34);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_state",   {62'd0, state},       64'd0);
        check("midrst_cpu_rst", {63'd0, cpu_rst},     64'd1);
        check("midrst_valid",   {63'd0, trace_valid}, 64'd0);
        check("midrst_cnt",     {48'd0, cycle_cnt},   64'd0);
        check("midrst_done",    {63'd0, done},        64'd0);
        trace_ready = 1'b1;
        step();
        check("midrst_stay_empty", {63'd0, trace_valid}, 64'd0);
        check("midrst_stay_idle",  {62'd0, state},       64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
